perceptron_train_sequencer: RTL and testbench
=============================================

Name: perceptron_train_sequencer

Overview:
Upstream stimulus stage for the perceptron core. It walks the full truth table of INPUT_UNITS binary inputs for NUM_EPOCHS epochs, driving values/expected/training into the core. It then switches to inference mode, driving values from synchronised board inputs. It replaces hand-written per-top training case logic with one reusable, parameterised sequencer.

Parameters:
INPUT_UNITS, 2, number of perceptron inputs; dataset size NUM_SAMPLES = 2**INPUT_UNITS (localparam).
NUM_EPOCHS, 10, full passes over the dataset before inference; must be >= 1.
SETTLE_CYCLES, 2, cycles each sample is held on the outputs; must be >= 1.
TARGET_MASK, 4'b1000, width NUM_SAMPLES; bit s gives the expected class of sample s (default is AND).
SYNC_STAGES, 2, flop depth of the raw_in synchroniser; must be >= 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  level sampled each clk; begins or restarts training when accepted.
raw_in  in  INPUT_UNITS  asynchronous board inputs used in inference.
values  out  INPUT_UNITS x sfp  perceptron input vector.
expected  out  sfp  training target for the current sample.
training  out  1  high while the core must apply weight updates.
sample_valid  out  1  one-cycle pulse on the first cycle a new sample is driven.
done  out  1  high in INFER; low otherwise.
epoch_count  out  $clog2(NUM_EPOCHS+1)  completed epochs.
sample_idx  out  $clog2(NUM_SAMPLES) (min 1)  current sample index.

Behaviour:
- All outputs are registered. On rst, asynchronously: state=IDLE, values=0, expected=0, training=0, sample_valid=0, done=0, epoch_count=0, sample_idx=0, and synchroniser flops=0.
- Sample s encoding: values[i] = SFP_ONE if bit i of s is 1, else SFP_ZERO. expected = SFP_ONE if TARGET_MASK[s] is 1, else SFP_ZERO.
- IDLE: training=0, values=0, expected=0. If start=1 at an edge, go to PRESENT with sample_idx=0 and epoch_count=0.
- PRESENT (1 cycle): drive sample sample_idx, training=1, sample_valid=1, and load hold_cnt=SETTLE_CYCLES-1.
  - If hold_cnt is 0, advance immediately; otherwise go to HOLD.
- HOLD: outputs stable, training=1, sample_valid=0. Decrement hold_cnt; advance when it reaches 0.
- Advance rules:
  - If sample_idx < NUM_SAMPLES-1: sample_idx+1, then PRESENT.
  - Else: sample_idx=0 and epoch_count+1.
    - If the new epoch_count equals NUM_EPOCHS: go to INFER with done=1 and training=0.
    - Otherwise: PRESENT.
- Timing: the first sample is visible the cycle after start is sampled. Total training duration is NUM_SAMPLES*NUM_EPOCHS*SETTLE_CYCLES cycles.
- INFER: training=0, expected=0, values[i] = SFP_ONE if sync(raw_in[i]) else SFP_ZERO. Latency from raw_in to values is SYNC_STAGES+1 edges.
  - epoch_count holds at NUM_EPOCHS.
  - sample_idx holds at 0.
- start handling:
  - Ignored in PRESENT and HOLD.
  - In INFER, start=1 restarts: go to PRESENT with sample 0, epoch_count=0, done=0.
- rst asserted mid-operation (any state) behaves as a power-on reset. Training is not resumed after rst deasserts; a new start is required.
- The synchroniser runs continuously in all states.
- No arithmetic beyond counters. Counters never wrap because terminal conditions are checked before increment.

Decomposition:
- FixedPoint package (existing): sfp type and int_to_sfp. Add constants SFP_ONE and SFP_ZERO there.
- New perceptron_pkg: seq_state_e enum {IDLE, PRESENT, HOLD, INFER}.
- One sub-module: bit_synchronizer #(WIDTH, STAGES), async-reset multi-flop synchroniser, instantiated once for raw_in.

Test Plan:
- Reset: assert rst mid-clock -> all outputs 0 immediately, without waiting for an edge, state IDLE; deassert with start=0 for 10 cycles -> outputs stay 0.
- Defaults, start pulse -> samples (values,expected) follow (0,0;0), (ONE,0;0), (0,ONE;0), (ONE,ONE;ONE), each held 2 cycles. sample_valid pulses every 2 cycles. done rises exactly 80 cycles after the first sample with epoch_count=10.
- In INFER, raw_in=2'b10 -> 3 edges later values[1]=ONE, values[0]=0, training=0, expected=0. Then raw_in=2'b01 -> values mirror it after 3 edges.
- start held high during training -> sequence and timing identical to the start-pulse case. start in INFER -> done=0, epoch_count=0, and sample 0 on the next cycle.
- rst asserted at epoch 4, sample 2 -> outputs 0. After release with start, training restarts from epoch 0, sample 0, and the full 80 cycles elapse before done.
- SETTLE_CYCLES=1, TARGET_MASK=4'b0110, NUM_EPOCHS=1 -> expected sequence 0,ONE,ONE,0 on consecutive cycles. sample_valid stays high for 4 cycles and done rises on the 5th.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared signed fixed-point format used across the perceptron datapath.
package fixed_point_pkg;
  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp SFP_ONE  = sfp'(1 <<< SFP_FRAC);
  localparam sfp SFP_ZERO = '0;

  function automatic sfp int_to_sfp(input int v);
    return sfp'(v <<< SFP_FRAC);
  endfunction
endpackage

// File: rtl/perceptron_pkg.sv
// Types shared by the perceptron training/inference control blocks.
package perceptron_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2,
    INFER   = 2'd3
  } seq_state_e;
endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for asynchronous board inputs, async-reset to zero.
module bit_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_bits,
  output logic [WIDTH-1:0] sync_bits
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_bits;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_bits = sync_q[STAGES-1];

endmodule

// File: rtl/perceptron_train_sequencer.sv
// Walks the binary truth table for NUM_EPOCHS epochs to train the perceptron
// core, then feeds synchronised board inputs for inference.
module perceptron_train_sequencer
  import fixed_point_pkg::*;
  import perceptron_pkg::*;
#(
  parameter int                          INPUT_UNITS   = 2,
  parameter int                          NUM_EPOCHS    = 10,
  parameter int                          SETTLE_CYCLES = 2,
  parameter logic [(2**INPUT_UNITS)-1:0] TARGET_MASK   = 4'b1000,
  parameter int                          SYNC_STAGES   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [INPUT_UNITS-1:0]                raw_in,
  output logic [INPUT_UNITS*SFP_W-1:0]          values,
  output logic [SFP_W-1:0]                      expected,
  output logic                                  training,
  output logic                                  sample_valid,
  output logic                                  done,
  output logic [$clog2(NUM_EPOCHS+1)-1:0]       epoch_count,
  output logic [(((2**INPUT_UNITS) > 1) ? $clog2(2**INPUT_UNITS) : 1)-1:0] sample_idx
);

  localparam int NUM_SAMPLES = 2**INPUT_UNITS;
  localparam int EW = $clog2(NUM_EPOCHS+1);
  localparam int IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int HW = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_SAMPLES-1);
  localparam logic [EW-1:0] LAST_EPOCH = EW'(NUM_EPOCHS-1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(SETTLE_CYCLES-1);

  seq_state_e                   state, state_d;
  logic [IW-1:0]                idx_d;
  logic [EW-1:0]                epoch_d;
  logic [HW-1:0]                hold_cnt, hold_d;
  logic                         advance;
  logic [INPUT_UNITS-1:0]       raw_sync;

  logic [INPUT_UNITS*SFP_W-1:0] values_d;
  sfp                           expected_d;
  logic                         training_d;
  logic                         sample_valid_d;
  logic                         done_d;

  function automatic logic [INPUT_UNITS*SFP_W-1:0] encode_bits(input logic [INPUT_UNITS-1:0] b);
    logic [INPUT_UNITS*SFP_W-1:0] r;
    r = '0;
    for (int i = 0; i < INPUT_UNITS; i++) begin
      r[i*SFP_W +: SFP_W] = b[i] ? SFP_ONE : SFP_ZERO;
    end
    return r;
  endfunction

  bit_synchronizer #(
    .WIDTH (INPUT_UNITS),
    .STAGES(SYNC_STAGES)
  ) u_raw_sync (
    .clk       (clk),
    .rst       (rst),
    .async_bits(raw_in),
    .sync_bits (raw_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sample_idx   <= '0;
      epoch_count  <= '0;
      hold_cnt     <= '0;
      values       <= '0;
      expected     <= '0;
      training     <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      sample_idx   <= idx_d;
      epoch_count  <= epoch_d;
      hold_cnt     <= hold_d;
      values       <= values_d;
      expected     <= expected_d;
      training     <= training_d;
      sample_valid <= sample_valid_d;
      done         <= done_d;
    end
  end

  // Terminal index/epoch are compared before incrementing, so counters never wrap.
  always_comb begin
    state_d = state;
    idx_d   = sample_idx;
    epoch_d = epoch_count;
    hold_d  = hold_cnt;
    advance = 1'b0;
    case (state)
      IDLE, INFER: begin
        if (start) begin
          state_d = PRESENT;
          idx_d   = '0;
          epoch_d = '0;
        end
      end
      PRESENT: begin
        if (HOLD_LOAD == '0) begin
          advance = 1'b1;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        hold_d = hold_cnt - 1'b1;
        if (hold_cnt <= HW'(1)) advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (sample_idx != LAST_IDX) begin
        idx_d   = sample_idx + 1'b1;
        state_d = PRESENT;
      end else begin
        idx_d   = '0;
        epoch_d = epoch_count + 1'b1;
        state_d = (epoch_count == LAST_EPOCH) ? INFER : PRESENT;
      end
    end
  end

  // Outputs are derived from the next state so they appear registered with it.
  always_comb begin
    values_d       = '0;
    expected_d     = SFP_ZERO;
    training_d     = 1'b0;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    case (state_d)
      PRESENT, HOLD: begin
        training_d     = 1'b1;
        sample_valid_d = (state_d == PRESENT);
        values_d       = encode_bits(INPUT_UNITS'(idx_d));
        expected_d     = TARGET_MASK[idx_d] ? SFP_ONE : SFP_ZERO;
      end
      INFER: begin
        done_d   = 1'b1;
        values_d = encode_bits(raw_sync);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Directed bench for the perceptron training sequencer (default and short configs).
module tb_perceptron_train_sequencer;

  localparam logic [15:0] ONE = 16'h0100;

  logic        clk;
  logic        rst, start;
  logic [1:0]  raw_in;
  logic [31:0] values;
  logic [15:0] expected;
  logic        training, sample_valid, done;
  logic [3:0]  epoch_count;
  logic [1:0]  sample_idx;

  logic        rst_b, start_b;
  logic [1:0]  raw_in_b;
  logic [31:0] values_b;
  logic [15:0] expected_b;
  logic        training_b, sample_valid_b, done_b;
  logic [0:0]  epoch_count_b;
  logic [1:0]  sample_idx_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic v0;
    logic v1;
    logic ea;
    logic eb;
  } vec_t;
  vec_t tbl [4];

  perceptron_train_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start), .raw_in(raw_in),
    .values(values), .expected(expected), .training(training),
    .sample_valid(sample_valid), .done(done),
    .epoch_count(epoch_count), .sample_idx(sample_idx)
  );

  perceptron_train_sequencer #(
    .NUM_EPOCHS(1), .SETTLE_CYCLES(1), .TARGET_MASK(4'b0110)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .raw_in(raw_in_b),
    .values(values_b), .expected(expected_b), .training(training_b),
    .sample_valid(sample_valid_b), .done(done_b),
    .epoch_count(epoch_count_b), .sample_idx(sample_idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sv_of(input logic b);
    return b ? ONE : 16'h0000;
  endfunction

  function automatic logic [63:0] act_a();
    return {7'b0, training, sample_valid, done, epoch_count, sample_idx, values, expected};
  endfunction

  function automatic logic [63:0] mk_a(input logic tr, input logic sv, input logic dn,
                                       input logic [3:0] ep, input logic [1:0] ix,
                                       input logic [15:0] v1, input logic [15:0] v0,
                                       input logic [15:0] ex);
    return {7'b0, tr, sv, dn, ep, ix, v1, v0, ex};
  endfunction

  function automatic logic [63:0] act_b();
    return {10'b0, training_b, sample_valid_b, done_b, epoch_count_b, sample_idx_b, values_b, expected_b};
  endfunction

  function automatic logic [63:0] mk_b(input logic tr, input logic sv, input logic dn,
                                       input logic ep, input logic [1:0] ix,
                                       input logic [15:0] v1, input logic [15:0] v0,
                                       input logic [15:0] ex);
    return {10'b0, tr, sv, dn, ep, ix, v1, v0, ex};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Checks 80 training cycles of the default instance starting at the current
  // negedge (first sample visible), then the INFER entry cycle; drops start.
  task automatic run_training(input string tag);
    int s;
    for (int c = 0; c <= 80; c++) begin
      if (c < 80) begin
        s = (c / 2) % 4;
        chk($sformatf("%s c%0d", tag, c), act_a(),
            mk_a(1'b1, (c % 2) == 0, 1'b0, 4'(c / 8), 2'(s),
                 sv_of(tbl[s].v1), sv_of(tbl[s].v0), sv_of(tbl[s].ea)));
        @(negedge clk);
      end else begin
        chk($sformatf("%s done", tag), act_a(),
            mk_a(1'b0, 1'b0, 1'b1, 4'd10, 2'd0, 16'h0, 16'h0, 16'h0));
        start = 1'b0;
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; raw_in = 2'b00;
    rst_b = 1'b1; start_b = 1'b0; raw_in_b = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset held", act_a(), 64'h0);
    rst = 1'b0;

    // Idle with start low: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d", i), act_a(), 64'h0);
    end

    // Single start pulse.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_training("pulse");

    // Inference: synchronised raw_in, SYNC_STAGES+1 edges of latency.
    raw_in = 2'b10;
    repeat (2) @(negedge clk);
    chk("infer10 early", {32'b0, values}, {32'b0, 16'h0, 16'h0});
    @(negedge clk);
    chk("infer10", act_a(), mk_a(1'b0, 1'b0, 1'b1, 4'd10, 2'd0, ONE, 16'h0, 16'h0));
    raw_in = 2'b01;
    repeat (2) @(negedge clk);
    chk("infer01 early", {32'b0, values}, {32'b0, ONE, 16'h0});
    @(negedge clk);
    chk("infer01", act_a(), mk_a(1'b0, 1'b0, 1'b1, 4'd10, 2'd0, 16'h0, ONE, 16'h0));

    // Restart from INFER with start held high through training.
    raw_in = 2'b00;
    start = 1'b1;
    @(negedge clk);
    run_training("held");

    // Reset in the middle of epoch 4, sample 2.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);
    chk("pre-rst pos", {60'b0, epoch_count, sample_idx, sample_valid, training},
        {60'b0, 4'd4, 2'd2, 1'b1, 1'b1});
    #2 rst = 1'b1;
    #1 chk("rst async", act_a(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst no resume", act_a(), 64'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_training("post-rst");

    // Short config: SETTLE_CYCLES=1, NUM_EPOCHS=1, TARGET_MASK=4'b0110.
    rst_b = 1'b0;
    @(negedge clk);
    chk("b idle", act_b(), 64'h0);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("b c%0d", c), act_b(),
          mk_b(1'b1, 1'b1, 1'b0, 1'b0, 2'(c),
               sv_of(tbl[c].v1), sv_of(tbl[c].v0), sv_of(tbl[c].eb)));
      @(negedge clk);
    end
    chk("b done", act_b(), mk_b(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0, 16'h0, 16'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
